me_fifo_ctrl: RTL and testbench

//  Sequencer for the ME reference-row FIFO.

---
 rtl/me_pkg.sv | 30 +++
 rtl/me_tag_delay.sv | 54 +++++
 rtl/me_fifo_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_me_fifo_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/me_pkg.sv
// ---------------------------------------------------------------------------
// me_pkg
// Shared types and constants for the motion-estimation reference-row FIFO
// sequencer (me_fifo_ctrl) and its tag delay line (me_tag_delay).
//   state_e : sequencer states
//   tag_t   : candidate-window tag {row, voff, last} that travels with a row
// ---------------------------------------------------------------------------
package me_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  // A reference row is 16 window bytes plus 7 bytes of horizontal search span,
  // giving 8 candidate 16-byte windows per row.
  localparam int ROW_BYTES = 23;
  localparam int WIN_BYTES = 16;
  localparam int N_CAND    = 8;
  localparam int ROW_W     = ROW_BYTES * 8;

  typedef struct packed {
    logic [3:0] row;
    logic [2:0] voff;
    logic       last;
  } tag_t;

endpackage

// File: rtl/me_tag_delay.sv
// ---------------------------------------------------------------------------
// me_tag_delay
// LAT-deep shift line carrying a valid bit and a tag_t alongside the FIFO
// shift, so the tag appears exactly when the FIFO taps become valid.
// Ports:
//   clk_i, rst_n_i : clock, asynchronous active-low reset (clears the line)
//   valid_i/tag_i  : shift strobe and the tag of the row being shifted in
//   valid_o/tag_o  : delayed strobe/tag (registered, last stage)
//   inflight_o     : a tag is in a stage before the output stage
// ---------------------------------------------------------------------------
module me_tag_delay
  import me_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic valid_i,
  input  tag_t tag_i,
  output logic valid_o,
  output tag_t tag_o,
  output logic inflight_o
);

  logic [LAT-1:0]       valid_q;
  tag_t [LAT-1:0]       tag_q;

  // Shift valid and tag one stage per cycle; idle stages hold a zero tag.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= '0;
      tag_q   <= '0;
    end else begin
      valid_q[0] <= valid_i;
      tag_q[0]   <= valid_i ? tag_i : '0;
      for (int i = 1; i < LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        tag_q[i]   <= tag_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[LAT-1];
  assign tag_o   = tag_q[LAT-1];

  // The output stage is already presented to the SAD tree, so only the
  // earlier stages count as "in flight" for sweep completion.
  if (LAT > 1) begin : g_multi
    assign inflight_o = |valid_q[LAT-2:0];
  end else begin : g_single
    assign inflight_o = 1'b0;
  end

endmodule

// File: rtl/me_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// me_fifo_ctrl
// Sequencer for the ME reference-row FIFO. One start sweeps all vertical
// offsets v = 0..SR_V-1 and rows r = 0..ROWS-1, requesting the row at
// base + (v+r)*stride (mod 2^AW), pulsing the FIFO shift on each return and
// tagging the resulting candidate taps with {row, voff, last}.
// Optional feature: define ME_STALL_CNT_EN to add stall_cnt_o, a saturating
// count of request cycles that were not granted.
// Ports:
//   clk_i, rst_n_i         : clock, asynchronous active-low reset
//   start_i                : start a sweep (only honoured in IDLE)
//   base_addr_i, stride_i  : captured on an accepted start
//   busy_o, done_o         : sweep active / 1-cycle end-of-sweep pulse
//   mem_req_o, mem_addr_o  : row read request, address held until granted
//   mem_gnt_i, mem_rvalid_i: grant, in-order row return
//   fifo_shift_o           : combinational shift strobe with returned data
//   cand_valid_o/row/voff/last : registered tag of current FIFO taps
//   stall_cnt_o            : only with ME_STALL_CNT_EN
// ---------------------------------------------------------------------------
module me_fifo_ctrl
  import me_pkg::*;
#(
  parameter int AW       = 20,
  parameter int ROWS     = 16,
  parameter int SR_V     = 8,
  parameter int FIFO_LAT = 1
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          start_i,
  input  logic [AW-1:0] base_addr_i,
  input  logic [AW-1:0] stride_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          mem_req_o,
  output logic [AW-1:0] mem_addr_o,
  input  logic          mem_gnt_i,
  input  logic          mem_rvalid_i,
  output logic          fifo_shift_o,
  output logic          cand_valid_o,
  output logic [3:0]    cand_row_o,
  output logic [2:0]    cand_voff_o,
  output logic          cand_last_o
`ifdef ME_STALL_CNT_EN
  ,
  output logic [15:0]   stall_cnt_o
`endif
);

  localparam int         TOTAL = ROWS * SR_V;
  localparam int         CW    = $clog2(TOTAL + 1);
  localparam logic [3:0] R_MAX = 4'(ROWS - 1);
  localparam logic [2:0] V_MAX = 3'(SR_V - 1);

  state_e          state_q;
  logic            busy_q, done_q, req_q;

  logic [AW-1:0]   row_addr_q, row_addr_d;
  logic [AW-1:0]   vbase_q, vbase_d;
  logic [AW-1:0]   stride_q, stride_d;
  logic [3:0]      r_iss_q, r_iss_d;
  logic [2:0]      v_iss_q, v_iss_d;
  logic [3:0]      r_ret_q, r_ret_d;
  logic [2:0]      v_ret_q, v_ret_d;
  logic [CW-1:0]   ret_cnt_q, ret_cnt_d;

  logic            start_acc_s, grant_s, r_wrap_s, last_grant_s;
  logic            ret_s, inflight_s, drain_done_s;
  tag_t            tag_in_s, cand_tag_s;

  assign start_acc_s  = (state_q == IDLE) && start_i;
  assign grant_s      = req_q && mem_gnt_i;
  assign r_wrap_s     = (r_iss_q == R_MAX);
  assign last_grant_s = grant_s && r_wrap_s && (v_iss_q == V_MAX);
  // Returns outside ISSUE/WAIT belong to an aborted sweep and are dropped.
  assign ret_s        = mem_rvalid_i && busy_q;
  assign drain_done_s = (ret_cnt_q == CW'(TOTAL)) && !inflight_s;

  assign tag_in_s.row  = r_ret_q;
  assign tag_in_s.voff = v_ret_q;
  assign tag_in_s.last = (r_ret_q == R_MAX);

  // Sequencer FSM with registered busy/done/request outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= ISSUE;
            busy_q  <= 1'b1;
            req_q   <= 1'b1;
          end
        end
        ISSUE: begin
          if (last_grant_s) begin
            state_q <= WAIT;
            req_q   <= 1'b0;
          end
        end
        WAIT: begin
          if (drain_done_s) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  // Next-state for issue address walk and return-side counters.
  always_comb begin
    row_addr_d = row_addr_q;
    vbase_d    = vbase_q;
    stride_d   = stride_q;
    r_iss_d    = r_iss_q;
    v_iss_d    = v_iss_q;
    r_ret_d    = r_ret_q;
    v_ret_d    = v_ret_q;
    ret_cnt_d  = ret_cnt_q;
    if (start_acc_s) begin
      row_addr_d = base_addr_i;
      vbase_d    = base_addr_i;
      stride_d   = stride_i;
      r_iss_d    = 4'd0;
      v_iss_d    = 3'd0;
      r_ret_d    = 4'd0;
      v_ret_d    = 3'd0;
      ret_cnt_d  = '0;
    end else begin
      // Incremental addressing: vbase tracks base + v*stride, so the first
      // row of the next offset is vbase + stride.
      if (grant_s) begin
        if (r_wrap_s) begin
          r_iss_d    = 4'd0;
          v_iss_d    = v_iss_q + 3'd1;
          vbase_d    = vbase_q + stride_q;
          row_addr_d = vbase_q + stride_q;
        end else begin
          r_iss_d    = r_iss_q + 4'd1;
          row_addr_d = row_addr_q + stride_q;
        end
      end else begin
        row_addr_d = row_addr_q;
      end
      if (ret_s) begin
        ret_cnt_d = ret_cnt_q + CW'(1);
        if (r_ret_q == R_MAX) begin
          r_ret_d = 4'd0;
          v_ret_d = v_ret_q + 3'd1;
        end else begin
          r_ret_d = r_ret_q + 4'd1;
        end
      end else begin
        ret_cnt_d = ret_cnt_q;
      end
    end
  end

  // Datapath registers; reset clears any partial sweep.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      row_addr_q <= '0;
      vbase_q    <= '0;
      stride_q   <= '0;
      r_iss_q    <= 4'd0;
      v_iss_q    <= 3'd0;
      r_ret_q    <= 4'd0;
      v_ret_q    <= 3'd0;
      ret_cnt_q  <= '0;
    end else begin
      row_addr_q <= row_addr_d;
      vbase_q    <= vbase_d;
      stride_q   <= stride_d;
      r_iss_q    <= r_iss_d;
      v_iss_q    <= v_iss_d;
      r_ret_q    <= r_ret_d;
      v_ret_q    <= v_ret_d;
      ret_cnt_q  <= ret_cnt_d;
    end
  end

  me_tag_delay #(
    .LAT (FIFO_LAT)
  ) u_tag_delay (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .valid_i    (ret_s),
    .tag_i      (tag_in_s),
    .valid_o    (cand_valid_o),
    .tag_o      (cand_tag_s),
    .inflight_o (inflight_s)
  );

`ifdef ME_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  // Saturating count of requested-but-denied cycles for the current sweep.
  always_comb begin
    stall_d = stall_q;
    if (start_acc_s) begin
      stall_d = 16'd0;
    end else if (req_q && !mem_gnt_i && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end else begin
      stall_d = stall_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_q <= 16'd0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt_o = stall_q;
`endif

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign mem_req_o    = req_q;
  assign mem_addr_o   = row_addr_q;
  assign fifo_shift_o = ret_s;
  assign cand_row_o   = cand_tag_s.row;
  assign cand_voff_o  = cand_tag_s.voff;
  assign cand_last_o  = cand_tag_s.last;

endmodule

// File: tb/tb_me_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_me_fifo_ctrl
// Scoreboard bench for me_fifo_ctrl: expected addresses are generated from
// base + (v+r)*stride, expected tags are pushed as the memory model returns
// rows and popped when cand_valid_o appears.
// ---------------------------------------------------------------------------
module tb_me_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [19:0] base_addr = 20'd0;
  logic [19:0] stride = 20'd0;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;

  logic        busy, done, mem_req, fifo_shift, cand_valid, cand_last;
  logic [19:0] mem_addr;
  logic [3:0]  cand_row;
  logic [2:0]  cand_voff;
`ifdef ME_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int cyc;
    int row;
    int voff;
    int last;
  } exp_tag_t;

  me_fifo_ctrl dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .start_i      (start),
    .base_addr_i  (base_addr),
    .stride_i     (stride),
    .busy_o       (busy),
    .done_o       (done),
    .mem_req_o    (mem_req),
    .mem_addr_o   (mem_addr),
    .mem_gnt_i    (mem_gnt),
    .mem_rvalid_i (mem_rvalid),
    .fifo_shift_o (fifo_shift),
    .cand_valid_o (cand_valid),
    .cand_row_o   (cand_row),
    .cand_voff_o  (cand_voff),
    .cand_last_o  (cand_last)
`ifdef ME_STALL_CNT_EN
    ,
    .stall_cnt_o  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string pfx);
    check_eq({pfx, "_busy"},   32'(busy), 32'd0);
    check_eq({pfx, "_done"},   32'(done), 32'd0);
    check_eq({pfx, "_req"},    32'(mem_req), 32'd0);
    check_eq({pfx, "_addr"},   32'(mem_addr), 32'd0);
    check_eq({pfx, "_shift"},  32'(fifo_shift), 32'd0);
    check_eq({pfx, "_cvalid"}, 32'(cand_valid), 32'd0);
    check_eq({pfx, "_crow"},   32'(cand_row), 32'd0);
    check_eq({pfx, "_cvoff"},  32'(cand_voff), 32'd0);
    check_eq({pfx, "_clast"},  32'(cand_last), 32'd0);
  endtask

  // gmode 0: grant always, 1: grant on odd cycles. abort_at >= 0 asserts
  // reset when that many grants are done. pulse_busy re-pulses start.
  task automatic run_sweep(input logic [19:0] b, input logic [19:0] s, input int gmode,
                           input int lat, input int bursty, input int abort_at,
                           input int pulse_busy);
    logic [19:0] aq[$];
    int          pend[$];
    exp_tag_t    tq[$];
    exp_tag_t    e;
    logic [31:0] a32;
    int          cyc, grants, rets, er, ev, exp_done, stalls;
    bit          done_seen;

    cyc = 0; grants = 0; rets = 0; er = 0; ev = 0; exp_done = -1; stalls = 0;
    done_seen = 1'b0;
    for (int v = 0; v < 8; v++) begin
      for (int r = 0; r < 16; r++) begin
        a32 = 32'(b) + 32'(v + r) * 32'(s);
        aq.push_back(a32[19:0]);
      end
    end

    @(negedge clk);
    base_addr = b; stride = s; start = 1'b1; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check_eq("busy_after_start", 32'(busy), 32'd1);

    while (!done_seen && cyc < 3000) begin
      // registered outputs for this cycle
      check_eq("cand_valid", 32'(cand_valid), 32'((tq.size() > 0 && tq[0].cyc == cyc) ? 1 : 0));
      if (cand_valid && tq.size() > 0) begin
        e = tq.pop_front();
        check_eq("cand_row", 32'(cand_row), 32'(e.row));
        check_eq("cand_voff", 32'(cand_voff), 32'(e.voff));
        check_eq("cand_last", 32'(cand_last), 32'(e.last));
      end
      check_eq("done", 32'(done), 32'((cyc == exp_done) ? 1 : 0));
      if (done) begin
        done_seen = 1'b1;
      end else if (abort_at >= 0 && grants == abort_at) begin
        mem_rvalid = 1'b1;
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        mem_rvalid = 1'b0;
        start = 1'b0;
        return;
      end else begin
        mem_gnt    = (gmode == 0) ? 1'b1 : ((cyc % 2) == 1);
        mem_rvalid = (pend.size() > 0 && pend[0] <= cyc &&
                      (bursty == 0 || ((cyc / 3) % 4) != 1));
        start      = (pulse_busy != 0 && (cyc % 9) == 4);
        #1;
        check_eq("shift", 32'(fifo_shift), 32'(mem_rvalid));
        if (mem_rvalid) begin
          void'(pend.pop_front());
          tq.push_back('{cyc + 1, er, ev, (er == 15) ? 1 : 0});
          if (er == 15) begin
            er = 0;
            ev++;
          end else begin
            er++;
          end
          rets++;
          if (rets == 128) exp_done = cyc + 2;
        end
        if (mem_req) begin
          if (aq.size() == 0) begin
            check_eq("req_extra", 32'd1, 32'd0);
          end else begin
            check_eq("addr", 32'(mem_addr), 32'(aq[0]));
            if (mem_gnt) begin
              void'(aq.pop_front());
              pend.push_back(cyc + lat);
              grants++;
            end else begin
              stalls++;
            end
          end
        end
        cyc++;
        @(negedge clk);
      end
    end

    start = 1'b0; mem_rvalid = 1'b0; mem_gnt = 1'b0;
    if (!done_seen) check_eq("timeout", 32'd1, 32'd0);
    check_eq("grant_count", 32'(grants), 32'd128);
    check_eq("return_count", 32'(rets), 32'd128);
    check_eq("addr_left", 32'(aq.size()), 32'd0);
    check_eq("tag_left", 32'(tq.size()), 32'd0);
`ifdef ME_STALL_CNT_EN
    check_eq("stall_cnt", 32'(stall_cnt), 32'(stalls));
`endif
    @(negedge clk);
    check_eq("done_one_cycle", 32'(done), 32'd0);
    check_eq("idle_busy", 32'(busy), 32'd0);
    check_eq("idle_req", 32'(mem_req), 32'd0);
`ifdef ME_STALL_CNT_EN
    check_eq("stall_held", 32'(stall_cnt), 32'(stalls));
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    #2;
    check_all_zero("reset");
    #4;
    rst_n = 1'b1;

    // grants and returns every cycle
    run_sweep(20'h00100, 20'h00020, 0, 1, 0, -1, 0);
    // grant toggling, address must hold across denied cycles
    run_sweep(20'h00100, 20'h00020, 1, 1, 0, -1, 0);
    // return latency 5 with bursty rvalid
    run_sweep(20'h00100, 20'h00020, 0, 5, 1, -1, 0);
    // start pulsed while busy is ignored
    run_sweep(20'h00100, 20'h00020, 1, 2, 0, -1, 1);
    // reset with v=3, r=7 on the request port
    run_sweep(20'h00100, 20'h00020, 0, 1, 0, 55, 0);
    @(negedge clk);
    check_all_zero("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b1;
    #1;
    check_eq("idle_rvalid_shift", 32'(fifo_shift), 32'd0);
    @(negedge clk);
    mem_rvalid = 1'b0;
    check_eq("idle_rvalid_cand", 32'(cand_valid), 32'd0);
    check_eq("idle_rvalid_busy", 32'(busy), 32'd0);
    run_sweep(20'h00100, 20'h00020, 0, 1, 0, -1, 0);
    // address wrap mod 2^20
    run_sweep(20'hFFFE0, 20'h00020, 1, 3, 1, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
